// File: rtl/key_emit.sv
// key_emit: drains a small packet FIFO and serializes each 4-bit packet onto
// the active-low start/key0/key1 lines of the two-key packet protocol.
module key_emit #(
   parameter int PRE_CYCLES = 3,
   parameter int BIT_HOLD   = 1,
   parameter int GAP_CYCLES = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_valid,
   input  logic [3:0] pkt_data,
   output logic       pkt_ready,
   output logic       start_o,
   output logic       key0_o,
   output logic       key1_o,
   output logic       busy,
   output logic [7:0] sent_count
);

   localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int MAX_PB  = (PRE_CYCLES > BIT_HOLD) ? PRE_CYCLES : BIT_HOLD;
   localparam int CNT_MAX = (MAX_PB > GAP_CYCLES) ? MAX_PB : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(BIT_HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_BIT,
      S_GAP,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     bit_q, bit_d;
   logic [3:0]     sh_q, sh_d;

   logic [3:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;

   logic           start_q, start_d;
   logic           key0_q, key0_d;
   logic           key1_q, key1_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic [7:0]     sent_q, sent_d;

   logic           push;
   logic           pop;
   logic           done;

   // pkt_ready is itself a register equal to !full, so push needs no extra qualification.
   assign push = pkt_valid && ready_q;

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= pkt_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pop     = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               sh_d    = mem_q[rd_ptr_q];
               bit_d   = 2'd0;
               cnt_d   = '0;
               state_d = S_PRE;
            end
         end
         S_PRE: begin
            if (cnt_q == PRE_LAST) begin
               cnt_d   = '0;
               state_d = S_BIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BIT: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  sh_d    = {sh_q[2:0], 1'b0};
                  bit_d   = bit_q + 1'b1;
                  state_d = (GAP_CYCLES == 0) ? S_BIT : S_GAP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_BIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so the lines line up with state_q.
   always_comb begin
      start_d = (state_d != S_PRE);
      key0_d  = !((state_d == S_BIT) && sh_d[3]);
      key1_d  = !((state_d == S_BIT) && !sh_d[3]);
      ready_d = (count_d != DEPTH);
      busy_d  = (state_d != S_IDLE) || (count_d != '0);
      sent_d  = done ? sent_q + 8'd1 : sent_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= 2'd0;
         sh_q     <= 4'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         start_q  <= 1'b1;
         key0_q   <= 1'b1;
         key1_q   <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         sent_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         start_q  <= start_d;
         key0_q   <= key0_d;
         key1_q   <= key1_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         sent_q   <= sent_d;
      end
   end

   assign pkt_ready  = ready_q;
   assign start_o    = start_q;
   assign key0_o     = key0_q;
   assign key1_o     = key1_q;
   assign busy       = busy_q;
   assign sent_count = sent_q;

endmodule
